// File: rtl/timer_sequencer.sv
// Interval-timer controller that drives an external loadable up/down counter.
// Provides one-shot and periodic modes, pause/resume, stop and terminal-count events.
module timer_sequencer #(
  parameter int unsigned TW = 32,
  parameter int unsigned EW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          clear,
  input  logic          cfg_periodic,
  input  logic          cfg_up,
  input  logic [TW-1:0] cfg_period,
  input  logic [TW-1:0] cnt_value,
  output logic          cnt_rst,
  output logic          cnt_load,
  output logic          cnt_up_not_down,
  output logic [TW-1:0] cnt_load_value,
  output logic          busy,
  output logic          tick,
  output logic          done,
  output logic [EW-1:0] event_count
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StPaused
  } state_e;

  state_e        state_q, state_d;
  logic          periodic_q, periodic_d;
  logic          up_q, up_d;
  logic [TW-1:0] period_q, period_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic [EW-1:0] ev_q, ev_d;

  logic          term;
  logic [TW-1:0] reload_value;

  // Up-count runs 0..period, down-count runs period..0.
  assign term         = up_q ? (cnt_value == period_q) : (cnt_value == '0);
  assign reload_value = up_q ? '0 : period_q;

  assign cnt_rst         = rst | (clear & (state_q == StIdle));
  assign cnt_up_not_down = up_q;
  assign busy            = (state_q != StIdle);
  assign tick            = tick_q;
  assign done            = done_q;
  assign event_count     = ev_q;

  always_comb begin
    state_d        = state_q;
    periodic_d     = periodic_q;
    up_d           = up_q;
    period_d       = period_q;
    tick_d         = 1'b0;
    done_d         = 1'b0;
    ev_d           = ev_q;
    // The counter has no enable, so holding means reloading its own value.
    cnt_load       = 1'b1;
    cnt_load_value = cnt_value;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          periodic_d = cfg_periodic;
          up_d       = cfg_up;
          period_d   = cfg_period;
          ev_d       = '0;
          state_d    = StLoad;
        end
      end

      StLoad: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          cnt_load_value = reload_value;
          state_d        = StRun;
        end
      end

      StRun: begin
        if (stop) begin
          // Abort wins over a coincident terminal count: no event is recorded.
          state_d = StIdle;
        end else if (!term) begin
          cnt_load = 1'b0;
          if (pause) begin
            state_d = StPaused;
          end
        end else begin
          tick_d = 1'b1;
          ev_d   = ev_q + EW'(1);
          if (periodic_q) begin
            cnt_load_value = reload_value;
            if (pause) begin
              state_d = StPaused;
            end
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StPaused: begin
        if (stop) begin
          state_d = StIdle;
        end else if (!pause) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      periodic_q <= 1'b0;
      up_q       <= 1'b0;
      period_q   <= '0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      ev_q       <= '0;
    end else begin
      state_q    <= state_d;
      periodic_q <= periodic_d;
      up_q       <= up_d;
      period_q   <= period_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      ev_q       <= ev_d;
    end
  end

endmodule
